// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with a hold-until-ack output register.
// Flags framing errors (one-cycle pulse) and overruns (sticky until ack).
module uart_rx #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ack_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int TICK_DIV = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [2:0]    b_q, b_d;
    logic [7:0]    sh_q, sh_d;
    logic [TW-1:0] tick_cnt;
    logic          tick, tick_clr;
    logic          rx_p0, rx_s, rx_prev;
    logic          vld_d, vld_p0, ferr_d;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        b_d      = b_q;
        sh_d     = sh_q;
        tick_clr = 1'b0;
        vld_d    = 1'b0;
        ferr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Edge-triggered so a line stuck low cannot start back-to-back frames.
                if (rx_prev && !rx_s) begin
                    state_d  = START;
                    s_d      = 4'd0;
                    tick_clr = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        s_d     = 4'd0;
                        b_d     = 3'd0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        sh_d = {rx_s, sh_q[7:1]};
                        s_d  = 4'd0;
                        b_d  = b_q + 3'd1;
                        if (b_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        state_d = IDLE;
                        s_d     = 4'd0;
                        vld_d   = rx_s;
                        ferr_d  = !rx_s;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_p0    <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            tick_cnt <= '0;
            state_q  <= IDLE;
            s_q      <= 4'd0;
            b_q      <= 3'd0;
        end else begin
            rx_p0    <= rx_i;
            rx_s     <= rx_p0;
            rx_prev  <= rx_s;
            tick_cnt <= (tick_clr || tick) ? '0 : tick_cnt + TW'(1);
            state_q  <= state_d;
            s_q      <= s_d;
            b_q      <= b_d;
        end
    end

    always_ff @(posedge clk_i) begin
        sh_q <= sh_d;
    end

    // Stop-bit sample -> delivery stage: vld_p0 carries the completed shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0      <= 1'b0;
            frame_err_o <= 1'b0;
            rx_data_o   <= 8'h00;
            rx_valid_o  <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            vld_p0      <= vld_d;
            frame_err_o <= ferr_d;
            if (vld_p0) begin
                if (!rx_valid_o || rx_ack_i) begin
                    rx_data_o  <= sh_q;
                    rx_valid_o <= 1'b1;
                    if (rx_ack_i) begin
                        overrun_o <= 1'b0;
                    end
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_ack_i) begin
                rx_valid_o <= 1'b0;
                overrun_o  <= 1'b0;
            end
        end
    end

endmodule
